// File: rtl/avmm_fir_coef_bank_if.sv
// Avalon-MM bus bundle between the Nios mm_bridge master and the FIR
// coefficient bank.
//   master modport: drives address/read/write/writedata/byteenable/burstcount,
//                   receives readdata/readdatavalid/waitrequest.
//   slave modport : the mirror image, used by avmm_fir_coef_bank.
interface avmm_fir_coef_bank_if #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 4
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic [BURST_W-1:0]  burstcount;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;

  modport master (
    output address, read, write, writedata, byteenable, burstcount,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, read, write, writedata, byteenable, burstcount,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/avmm_fir_coef_bank.sv
// FIR coefficient bank and GPIO register block on an Avalon-MM slave.
// The CPU writes shadow coefficients; a commit copies shadow->active one tap
// per cycle while the FIR datapath consumes the active set.
// Ports:
//   clk_clk      sole clock
//   reset_reset  asynchronous, active-high reset
//   s0           Avalon-MM slave (pipelined reads, latency 2, bursts)
//   pio_export   GPIO outputs
//   coef_active  active coefs, tap i at [i*COEF_W +: COEF_W]
//   coef_busy    high while a commit copy runs
//   coef_update  one-cycle pulse after a commit copy completes
//
// Commit FSM
//   state | meaning
//   IDLE  | no copy in progress
//   COPY  | copying tap copy_idx_q shadow->active, bus stalled
//   DONE  | copy finished, coef_update pulses; a new commit may start here
module avmm_fir_coef_bank #(
  parameter int N_TAPS    = 16,
  parameter int COEF_W    = 16,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int BURST_W   = 4,
  parameter int MAX_BURST = 8,
  parameter int N_PIO     = 8
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  avmm_fir_coef_bank_if.slave      s0,
  output logic [N_PIO-1:0]         pio_export,
  output logic [N_TAPS*COEF_W-1:0] coef_active,
  output logic                     coef_busy,
  output logic                     coef_update
);

  localparam int BE_W  = DATA_W / 8;
  // One extra address bit so burst addresses run past the top of the map
  // instead of wrapping back onto CTRL/STATUS.
  localparam int AW1   = ADDR_W + 1;
  localparam int IDX_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;

  localparam logic [AW1-1:0] A_CTRL   = AW1'(0);
  localparam logic [AW1-1:0] A_STATUS = AW1'(1);
  localparam logic [AW1-1:0] A_PIO    = AW1'(2);
  localparam logic [AW1-1:0] A_SET    = AW1'(3);
  localparam logic [AW1-1:0] A_CLR    = AW1'(4);
  localparam logic [AW1-1:0] A_SH_LO  = AW1'(256);
  localparam logic [AW1-1:0] A_SH_HI  = AW1'(256 + N_TAPS);
  localparam logic [AW1-1:0] A_AC_LO  = AW1'(512);
  localparam logic [AW1-1:0] A_AC_HI  = AW1'(512 + N_TAPS);

  typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

  state_t             state_q, state_d;
  logic [COEF_W-1:0]  shadow_q [N_TAPS];
  logic [COEF_W-1:0]  active_q [N_TAPS];
  logic [N_PIO-1:0]   pio_q;
  logic               burst_err_q;
  logic               commit_pend_q;
  logic [IDX_W-1:0]   copy_idx_q;
  logic [BURST_W-1:0] rd_rem_q, wr_rem_q;
  logic [AW1-1:0]     rd_addr_q, wr_addr_q;
  logic               rd1_valid_q;
  logic [AW1-1:0]     rd1_addr_q;
  logic [DATA_W-1:0]  readdata_q;
  logic               readdatavalid_q;

  logic               wr_open, waitreq, rd_acc, wr_first, wr_beat, we;
  logic               wr_open_nxt, bc_bad, commit_hit, start_copy, commit_pend_d;
  logic               copy_last, w_sh, r_sh, r_ac, status_clr;
  logic [BURST_W-1:0] bc_rem;
  logic [AW1-1:0]     waddr;
  logic [DATA_W-1:0]  be_mask, rd_data;
  logic [IDX_W-1:0]   w_idx, r_sh_idx, r_ac_idx;
  logic [COEF_W-1:0]  coef_wr;
  logic [N_PIO-1:0]   pio_wd;

  always_comb begin
    wr_open  = (wr_rem_q != '0);
    // A read arriving inside an open write burst is held off; write beats
    // of that burst never see waitrequest.
    waitreq  = (state_q == COPY) | (rd_rem_q != '0) | (wr_open & s0.read & !s0.write);
    rd_acc   = s0.read & !s0.write & !waitreq & !wr_open;
    wr_first = s0.write & !waitreq & !wr_open;
    wr_beat  = s0.write & !waitreq & wr_open;
    we       = wr_first | wr_beat;
    waddr    = wr_first ? {1'b0, s0.address} : wr_addr_q;

    bc_bad   = (s0.burstcount == '0) || (s0.burstcount > BURST_W'(MAX_BURST));
    bc_rem   = bc_bad ? '0 : s0.burstcount - BURST_W'(1);

    if (wr_first)     wr_open_nxt = (bc_rem != '0);
    else if (wr_beat) wr_open_nxt = (wr_rem_q != BURST_W'(1));
    else              wr_open_nxt = wr_open;

    for (int b = 0; b < BE_W; b++) be_mask[8*b +: 8] = {8{s0.byteenable[b]}};

    w_sh    = (waddr >= A_SH_LO) && (waddr < A_SH_HI);
    w_idx   = IDX_W'(waddr - A_SH_LO);
    coef_wr = COEF_W'((DATA_W'(shadow_q[w_idx]) & ~be_mask) | (s0.writedata & be_mask));
    pio_wd  = s0.writedata[N_PIO-1:0] & be_mask[N_PIO-1:0];

    commit_hit    = we && (waddr == A_CTRL) && s0.byteenable[0] && s0.writedata[0];
    status_clr    = we && (waddr == A_STATUS) && s0.byteenable[0] && s0.writedata[1];
    // A commit inside an open write burst is parked until the burst ends.
    start_copy    = (commit_hit | commit_pend_q) & !wr_open_nxt & (state_q != COPY);
    commit_pend_d = (commit_hit | commit_pend_q) & !start_copy;
    copy_last     = (copy_idx_q == IDX_W'(N_TAPS - 1));
  end

  always_comb begin
    rd_data  = '0;
    r_sh     = (rd1_addr_q >= A_SH_LO) && (rd1_addr_q < A_SH_HI);
    r_ac     = (rd1_addr_q >= A_AC_LO) && (rd1_addr_q < A_AC_HI);
    r_sh_idx = IDX_W'(rd1_addr_q - A_SH_LO);
    r_ac_idx = IDX_W'(rd1_addr_q - A_AC_LO);
    if (rd1_addr_q == A_STATUS) rd_data = DATA_W'({burst_err_q, state_q == COPY});
    else if (rd1_addr_q == A_PIO) rd_data = DATA_W'(pio_q);
    else if (r_sh) rd_data = DATA_W'($signed(shadow_q[r_sh_idx]));
    else if (r_ac) rd_data = DATA_W'($signed(active_q[r_ac_idx]));
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    coef_busy   = 1'b0;
    coef_update = 1'b0;
    case (state_q)
      IDLE: if (start_copy) state_d = COPY;
      COPY: begin
        coef_busy = 1'b1;
        if (copy_last) state_d = DONE;
      end
      DONE: begin
        coef_update = 1'b1;
        state_d     = start_copy ? COPY : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int i = 0; i < N_TAPS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      pio_q           <= '0;
      burst_err_q     <= 1'b0;
      commit_pend_q   <= 1'b0;
      copy_idx_q      <= '0;
      rd_rem_q        <= '0;
      wr_rem_q        <= '0;
      rd_addr_q       <= '0;
      wr_addr_q       <= '0;
      rd1_valid_q     <= 1'b0;
      rd1_addr_q      <= '0;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
    end else begin
      // Read issue: beat 0 on the accept cycle, further burst beats follow
      // back to back while waitrequest holds off new commands.
      rd1_valid_q <= rd_acc | (rd_rem_q != '0);
      if (rd_acc) begin
        rd1_addr_q <= {1'b0, s0.address};
        rd_addr_q  <= {1'b0, s0.address} + AW1'(1);
        rd_rem_q   <= bc_rem;
      end else if (rd_rem_q != '0) begin
        rd1_addr_q <= rd_addr_q;
        rd_addr_q  <= rd_addr_q + AW1'(1);
        rd_rem_q   <= rd_rem_q - BURST_W'(1);
      end
      readdatavalid_q <= rd1_valid_q;
      if (rd1_valid_q) readdata_q <= rd_data;

      if (wr_first) begin
        wr_rem_q  <= bc_rem;
        wr_addr_q <= {1'b0, s0.address} + AW1'(1);
      end else if (wr_beat) begin
        wr_rem_q  <= wr_rem_q - BURST_W'(1);
        wr_addr_q <= wr_addr_q + AW1'(1);
      end

      if (we) begin
        if (waddr == A_PIO)      pio_q <= (pio_q & ~be_mask[N_PIO-1:0]) | pio_wd;
        else if (waddr == A_SET) pio_q <= pio_q | pio_wd;
        else if (waddr == A_CLR) pio_q <= pio_q & ~pio_wd;
        else if (w_sh)           shadow_q[w_idx] <= coef_wr;
      end

      if (status_clr) burst_err_q <= 1'b0;
      if ((rd_acc | wr_first) & bc_bad) burst_err_q <= 1'b1;

      commit_pend_q <= commit_pend_d;

      if (state_q == COPY) begin
        active_q[copy_idx_q] <= shadow_q[copy_idx_q];
        copy_idx_q           <= copy_last ? '0 : copy_idx_q + IDX_W'(1);
      end else begin
        copy_idx_q <= '0;
      end
    end
  end

  assign s0.readdata      = readdata_q;
  assign s0.readdatavalid = readdatavalid_q;
  assign s0.waitrequest   = waitreq;
  assign pio_export       = pio_q;

  for (genvar i = 0; i < N_TAPS; i++) begin : g_coef
    assign coef_active[i*COEF_W +: COEF_W] = active_q[i];
  end

endmodule

// File: tb/tb_avmm_fir_coef_bank.sv
`timescale 1ns/1ps
module tb_avmm_fir_coef_bank;
  localparam int N_TAPS = 16, COEF_W = 16, DATA_W = 32, ADDR_W = 10;
  localparam int BURST_W = 4, MAX_BURST = 8, N_PIO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N_PIO-1:0]         pio_export;
  logic [N_TAPS*COEF_W-1:0] coef_active;
  logic                     coef_busy, coef_update;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] pend[$];
  logic [31:0] sb_d[$];
  int          sb_c[$];

  avmm_fir_coef_bank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) bus ();

  avmm_fir_coef_bank #(
    .N_TAPS(N_TAPS), .COEF_W(COEF_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .BURST_W(BURST_W), .MAX_BURST(MAX_BURST), .N_PIO(N_PIO)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .s0          (bus),
    .pio_export  (pio_export),
    .coef_active (coef_active),
    .coef_busy   (coef_busy),
    .coef_update (coef_update)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: read beats are queued with data and due cycle at accept.
  always @(negedge clk) begin
    if (bus.readdatavalid) begin
      chk("rdv_pending", 256'(sb_d.size() != 0), 256'(1));
      if (sb_d.size() != 0) begin
        chk("rd_data", 256'(bus.readdata), 256'(sb_d.pop_front()));
        chk("rd_latency", 256'(cyc), 256'(sb_c.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_rd(input logic [31:0] d);
    pend.push_back(d);
  endtask

  task automatic wait_accept(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = !bus.waitrequest;
    end
    chk(tag, 256'(ok), 256'(1));
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be,
                    input logic [3:0] bc);
    bus.address = a; bus.writedata = d; bus.byteenable = be;
    bus.burstcount = bc; bus.write = 1'b1;
    wait_accept("wr_accept");
    step();
    bus.write = 1'b0;
  endtask

  // Beat k carries base-k; later beats drive a junk address and burstcount.
  task automatic wr_burst(input logic [9:0] a, input int n, input int base);
    for (int k = 0; k < n; k++) begin
      bus.address    = (k == 0) ? a : 10'h3FF;
      bus.burstcount = (k == 0) ? 4'(n) : 4'h0;
      bus.writedata  = 32'(base - k);
      bus.byteenable = 4'hF;
      bus.write      = 1'b1;
      wait_accept("wrb_accept");
      step();
      if (k == 2) begin
        bus.write = 1'b0;
        step();
      end
    end
    bus.write = 1'b0;
  endtask

  task automatic rd_singles(input logic [9:0] a, input int n);
    int t0;
    t0 = 0;
    for (int k = 0; k < n; k++) begin
      bus.address = a + 10'(k); bus.burstcount = 4'h1; bus.read = 1'b1;
      wait_accept("rd_accept");
      if (k == 0) t0 = cyc;
      else chk("rd_pipe_cycle", 256'(cyc), 256'(t0 + k));
      sb_d.push_back(pend.pop_front());
      sb_c.push_back(cyc + 2);
      step();
    end
    bus.read = 1'b0;
  endtask

  task automatic rd_burst(input logic [9:0] a, input logic [3:0] bc, input int nb,
                          output int wcnt);
    int t;
    bus.address = a; bus.burstcount = bc; bus.read = 1'b1;
    wait_accept("rdb_accept");
    t = cyc;
    for (int k = 0; k < nb; k++) begin
      sb_d.push_back(pend.pop_front());
      sb_c.push_back(t + 2 + k);
    end
    step();
    bus.read = 1'b0;
    wcnt = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (!bus.waitrequest) break;
      wcnt++;
    end
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb_d.size() != 0; i++) step();
    chk("drain", 256'(sb_d.size()), 256'(0));
  endtask

  task automatic watch_commit(output int busy_n, output int upd_n, output int wq_n);
    busy_n = 0; upd_n = 0; wq_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (coef_busy) busy_n++;
      if (coef_update) upd_n++;
      if (coef_busy && bus.waitrequest) wq_n++;
    end
    step();
  endtask

  initial begin
    int w, b, u, q;
    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0;
    bus.writedata = '0; bus.byteenable = '0; bus.burstcount = '0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pio", 256'(pio_export), 256'(0));
    chk("rst_coef", 256'(coef_active), 256'(0));
    chk("rst_busy", 256'(coef_busy), 256'(0));
    chk("rst_upd", 256'(coef_update), 256'(0));
    chk("rst_rdv", 256'(bus.readdatavalid), 256'(0));
    chk("rst_rdata", 256'(bus.readdata), 256'(0));
    chk("rst_wreq", 256'(bus.waitrequest), 256'(0));
    rst = 1'b0;
    step();

    exp_rd(32'h0); rd_singles(10'h002, 1); drain();

    wr_burst(10'h100, 8, -1);
    wr_burst(10'h108, 8, -9);
    exp_rd(32'h0); rd_singles(10'h200, 1);
    exp_rd(32'hFFFF_FFF1); exp_rd(32'hFFFF_FFF0); rd_singles(10'h10E, 2);
    drain();

    wr(10'h000, 32'h1, 4'h1, 4'h1);
    watch_commit(b, u, q);
    chk("commit_busy_cycles", 256'(b), 256'(16));
    chk("commit_update", 256'(u), 256'(1));
    chk("commit_wreq", 256'(q), 256'(16));
    chk("tap5", 256'(coef_active[5*COEF_W +: COEF_W]), 256'(16'hFFFA));
    chk("tap15", 256'(coef_active[15*COEF_W +: COEF_W]), 256'(16'hFFF0));
    exp_rd(32'hFFFF_FFFA); rd_singles(10'h205, 1); drain();

    exp_rd(32'hFFFF_FFFF); exp_rd(32'hFFFF_FFFE); exp_rd(32'hFFFF_FFFD); exp_rd(32'hFFFF_FFFC);
    rd_burst(10'h100, 4'd4, 4, w);
    chk("rdburst_wait", 256'(w), 256'(3));
    drain();
    exp_rd(32'hFFFF_FFF2); exp_rd(32'hFFFF_FFF1); exp_rd(32'hFFFF_FFF0); exp_rd(32'h0);
    rd_burst(10'h10D, 4'd4, 4, w);
    drain();

    wr(10'h002, 32'h0F, 4'hF, 4'h1);
    wr(10'h003, 32'hF0, 4'hF, 4'h1);
    wr(10'h004, 32'h03, 4'hF, 4'h1);
    chk("pio_set_clr", 256'(pio_export), 256'(8'hFC));
    wr(10'h002, 32'h55, 4'h0, 4'h1);
    chk("pio_be0", 256'(pio_export), 256'(8'hFC));
    exp_rd(32'hFC); rd_singles(10'h002, 1);

    wr(10'h101, 32'h1234_ABCD, 4'b0001, 4'h1);
    wr(10'h102, 32'h0000_1200, 4'b0010, 4'h1);
    wr(10'h104, 32'hABCD_0005, 4'hF, 4'h1);
    exp_rd(32'hFFFF_FFCD); exp_rd(32'h0000_12FD); rd_singles(10'h101, 2);
    exp_rd(32'h0); rd_singles(10'h001, 1);
    drain();

    wr(10'h103, 32'h7, 4'hF, 4'h0);
    wr(10'h105, 32'h9, 4'hF, 4'h1);
    exp_rd(32'h7); exp_rd(32'h5); exp_rd(32'h9); rd_singles(10'h103, 3);
    exp_rd(32'h2); rd_singles(10'h001, 1);
    drain();
    wr(10'h001, 32'h2, 4'h1, 4'h1);
    exp_rd(32'h0); rd_singles(10'h001, 1);
    exp_rd(32'h7); rd_burst(10'h103, 4'd9, 1, w);
    chk("rd_bad_burst_wait", 256'(w), 256'(0));
    exp_rd(32'h2); rd_singles(10'h001, 1);
    drain();
    wr(10'h001, 32'h2, 4'h1, 4'h1);

    wr(10'h000, 32'h1, 4'h1, 4'h1);
    repeat (5) step();
    chk("copy_running", 256'(coef_busy), 256'(1));
    rst = 1'b1;
    #1;
    chk("rst_mid_coef", 256'(coef_active), 256'(0));
    chk("rst_mid_busy", 256'(coef_busy), 256'(0));
    repeat (2) step();
    rst = 1'b0;
    watch_commit(b, u, q);
    chk("rst_no_update", 256'(u), 256'(0));
    chk("rst_no_busy", 256'(b), 256'(0));

    wr(10'h100, 32'h11, 4'hF, 4'h1);
    wr(10'h10F, 32'h22, 4'hF, 4'h1);
    wr(10'h000, 32'h1, 4'h1, 4'h1);
    watch_commit(b, u, q);
    chk("recommit_busy", 256'(b), 256'(16));
    chk("recommit_update", 256'(u), 256'(1));
    chk("recommit_taps", 256'(coef_active), {16'h0022, 224'h0, 16'h0011});
    exp_rd(32'h11); rd_singles(10'h200, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
